// File: rtl/s3g_packet_rx.sv
// s3g_packet_rx: framed packet receiver fed by a UART byte stream.
// Frame: 0xD5, length, payload[length], CRC-8/Maxim over the payload.
// A correct packet is held in the payload buffer until the consumer
// releases it with buf_ack. A frame that arrives while the buffer is held
// is reported as busy and skipped without touching the buffer.
//
// Handshake: rx_done qualifies rx_data for exactly one cycle and the block
// always accepts it (there is no back-pressure). buffer_valid rises when a
// packet is accepted and falls on the edge after buf_ack=1. If an accept
// and buf_ack land on the same cycle, the accept wins.
module s3g_packet_rx #(
  parameter int MAX_PAYLOAD    = 32,
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              buf_ack,
  output logic [7:0]        payload_len,
  output logic              buffer_valid,
  output logic              err_strobe,
  output logic [2:0]        err_code,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       err_cnt,
  output logic [2:0]        state_dbg
);

  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      SOF      = 8'hD5;
  localparam logic [7:0]      MAX_LEN  = 8'(MAX_PAYLOAD);

  localparam logic [2:0] ERR_LEN  = 3'd1;
  localparam logic [2:0] ERR_CRC  = 3'd2;
  localparam logic [2:0] ERR_TMO  = 3'd3;
  localparam logic [2:0] ERR_BUSY = 3'd4;

  // SKIP_LEN/SKIP consume a frame that arrived while the buffer was held.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LEN      = 3'd1,
    ST_PAYLOAD  = 3'd2,
    ST_CRC      = 3'd3,
    ST_SKIP_LEN = 3'd4,
    ST_SKIP     = 3'd5
  } state_t;

  state_t           state;
  logic [7:0]       len_q;
  logic [7:0]       idx_q;
  logic [7:0]       crc_q;
  logic [8:0]       skip_q;
  logic [TMO_W-1:0] tmo_q;

  logic [7:0] mem [2**ADDR_W];

  logic       wr_en;
  logic       tmo_hit;
  logic       accept;
  logic       err_fire;
  logic [2:0] err_cause;

  // One byte of reflected CRC-8, polynomial 0x8C, LSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  assign state_dbg = state;

  // Payload writes only happen in a live packet and never while a packet is held.
  assign wr_en   = (state == ST_PAYLOAD) && rx_done && !buffer_valid;
  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_hit = !rx_done && (state != ST_IDLE) && (tmo_q == TMO_LAST);

  // Classify the current cycle: accept, or which error (if any) fires.
  always_comb begin
    accept    = 1'b0;
    err_fire  = 1'b0;
    err_cause = 3'd0;
    if (rx_done) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == SOF && buffer_valid) begin
            err_fire  = 1'b1;
            err_cause = ERR_BUSY;
          end
        end
        ST_LEN: begin
          if (rx_data > MAX_LEN) begin
            err_fire  = 1'b1;
            err_cause = ERR_LEN;
          end
        end
        ST_CRC: begin
          if (rx_data == crc_q) begin
            accept = 1'b1;
          end else begin
            err_fire  = 1'b1;
            err_cause = ERR_CRC;
          end
        end
        default: ;
      endcase
    end else if (tmo_hit) begin
      err_fire  = 1'b1;
      err_cause = ERR_TMO;
    end
  end

  // Payload buffer storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx_q[ADDR_W-1:0]] <= rx_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

  // Frame FSM, inter-byte timeout, buffer ownership, status and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      len_q        <= 8'h00;
      idx_q        <= 8'h00;
      crc_q        <= 8'h00;
      skip_q       <= 9'd0;
      tmo_q        <= '0;
      payload_len  <= 8'h00;
      buffer_valid <= 1'b0;
      err_strobe   <= 1'b0;
      err_code     <= 3'd0;
      pkt_cnt      <= 16'h0000;
      err_cnt      <= 16'h0000;
    end else begin
      err_strobe <= err_fire;
      if (err_fire) begin
        err_code <= err_cause;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end

      if (accept) begin
        buffer_valid <= 1'b1;
        payload_len  <= len_q;
        if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
      end else if (buf_ack) begin
        buffer_valid <= 1'b0;
      end

      if (state == ST_IDLE || rx_done || tmo_hit) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end

      if (rx_done) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == SOF) state <= buffer_valid ? ST_SKIP_LEN : ST_LEN;
          end
          ST_LEN: begin
            len_q <= rx_data;
            idx_q <= 8'h00;
            crc_q <= 8'h00;
            if (rx_data > MAX_LEN)      state <= ST_IDLE;
            else if (rx_data == 8'h00)  state <= ST_CRC;
            else                        state <= ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            crc_q <= crc8_byte(crc_q, rx_data);
            idx_q <= idx_q + 8'd1;
            if (idx_q == len_q - 8'd1) state <= ST_CRC;
          end
          ST_CRC: begin
            state <= ST_IDLE;
          end
          ST_SKIP_LEN: begin
            // Oversized length while skipping: drop silently, the busy error already fired.
            if (rx_data > MAX_LEN) begin
              state <= ST_IDLE;
            end else begin
              skip_q <= {1'b0, rx_data} + 9'd1;
              state  <= ST_SKIP;
            end
          end
          ST_SKIP: begin
            skip_q <= skip_q - 9'd1;
            if (skip_q == 9'd1) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (tmo_hit) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_s3g_packet_rx.sv
// tb_s3g_packet_rx: directed byte streams for s3g_packet_rx with
// hand-computed expectations (CRC-8/Maxim: 01 -> 5E, "123456789" -> A1).
module tb_s3g_packet_rx;

  localparam int MAX_PAYLOAD    = 32;
  localparam int ADDR_W         = 5;
  localparam int TIMEOUT_CYCLES = 40;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_SKIP    = 3'd5;

  logic              osc_clk;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              buf_ack;
  logic [7:0]        payload_len;
  logic              buffer_valid;
  logic              err_strobe;
  logic [2:0]        err_code;
  logic [15:0]       pkt_cnt;
  logic [15:0]       err_cnt;
  logic [2:0]        state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  s3g_packet_rx #(
    .MAX_PAYLOAD(MAX_PAYLOAD),
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(osc_clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .buf_ack(buf_ack),
    .payload_len(payload_len),
    .buffer_valid(buffer_valid),
    .err_strobe(err_strobe),
    .err_code(err_code),
    .pkt_cnt(pkt_cnt),
    .err_cnt(err_cnt),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  initial osc_clk = 1'b0;
  always #5 osc_clk = ~osc_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drivers: called and returning on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge osc_clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge osc_clk);
  endtask

  task automatic pulse_ack();
    buf_ack = 1'b1;
    @(negedge osc_clk);
    buf_ack = 1'b0;
  endtask

  task automatic send_one_01();
    send_byte(8'hD5);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h5E);
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    rd_addr = '0;
    buf_ack = 1'b0;
    idle_cycles(3);

    // Reset values
    check("rst_buffer_valid", buffer_valid, 1'b0);
    check("rst_payload_len", payload_len, 8'h00);
    check("rst_err_strobe", err_strobe, 1'b0);
    check("rst_err_code", err_code, 3'd0);
    check("rst_pkt_cnt", pkt_cnt, 16'd0);
    check("rst_err_cnt", err_cnt, 16'd0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_state", state_dbg, S_IDLE);
    rst_n = 1'b1;
    idle_cycles(2);

    // D5 01 01 5E: valid exactly one cycle after the CRC byte
    send_byte(8'hD5);
    send_byte(8'h01);
    send_byte(8'h01);
    check("one_pre_valid", buffer_valid, 1'b0);
    send_byte(8'h5E);
    check("one_valid", buffer_valid, 1'b1);
    check("one_len", payload_len, 8'd1);
    check("one_pkt_cnt", pkt_cnt, 16'd1);
    rd_addr = 5'd0;
    idle_cycles(1);
    check("one_rd_data", rd_data, 8'h01);
    pulse_ack();
    check("one_ack_clears", buffer_valid, 1'b0);

    // Noise in IDLE is ignored
    send_byte(8'h33);
    send_byte(8'h01);
    check("noise_err_cnt", err_cnt, 16'd0);
    check("noise_state", state_dbg, S_IDLE);

    // Empty packet, then a CRC error
    send_byte(8'hD5);
    send_byte(8'h00);
    send_byte(8'h00);
    check("empty_valid", buffer_valid, 1'b1);
    check("empty_len", payload_len, 8'd0);
    check("empty_pkt_cnt", pkt_cnt, 16'd2);
    pulse_ack();
    send_byte(8'hD5);
    send_byte(8'h01);
    send_byte(8'h01);
    check("crc_no_strobe_yet", err_strobe, 1'b0);
    send_byte(8'h00);
    check("crc_strobe", err_strobe, 1'b1);
    check("crc_code", err_code, 3'd2);
    check("crc_err_cnt", err_cnt, 16'd1);
    check("crc_len_kept", payload_len, 8'd0);
    check("crc_no_valid", buffer_valid, 1'b0);
    idle_cycles(1);
    check("crc_strobe_one_cycle", err_strobe, 1'b0);
    check("crc_code_held", err_code, 3'd2);

    // Length 0x21 > MAX_PAYLOAD, then a normal packet
    send_byte(8'hD5);
    send_byte(8'h21);
    check("len_code", err_code, 3'd1);
    check("len_err_cnt", err_cnt, 16'd2);
    check("len_state", state_dbg, S_IDLE);
    send_one_01();
    check("len_recover_valid", buffer_valid, 1'b1);
    check("len_recover_pkt", pkt_cnt, 16'd3);
    pulse_ack();

    // "123456789" -> CRC A1, read back through the buffer
    send_byte(8'hD5);
    send_byte(8'd9);
    for (int i = 0; i < 9; i++) begin
      send_byte(8'h31 + 8'(i));
      exp_q.push_back(8'h31 + 8'(i));
    end
    send_byte(8'hA1);
    check("nine_valid", buffer_valid, 1'b1);
    check("nine_len", payload_len, 8'd9);
    check("nine_pkt_cnt", pkt_cnt, 16'd4);
    for (int i = 0; i < 9; i++) begin
      rd_addr = 5'(i);
      idle_cycles(1);
      check($sformatf("nine_rd[%0d]", i), rd_data, exp_q.pop_front());
    end

    // Busy: frame arrives while buffer held; skipped without writes
    send_byte(8'hD5);
    check("busy_strobe", err_strobe, 1'b1);
    check("busy_code", err_code, 3'd4);
    check("busy_err_cnt", err_cnt, 16'd3);
    send_byte(8'h01);
    check("busy_skip_state", state_dbg, S_SKIP);
    send_byte(8'h02);
    send_byte(8'h77);
    check("busy_back_idle", state_dbg, S_IDLE);
    check("busy_err_cnt_once", err_cnt, 16'd3);
    check("busy_valid_kept", buffer_valid, 1'b1);
    check("busy_len_kept", payload_len, 8'd9);
    rd_addr = 5'd0;
    idle_cycles(1);
    check("busy_buf_unchanged", rd_data, 8'h31);
    send_byte(8'hD5);
    send_byte(8'h40);
    check("busy_biglen_err_cnt", err_cnt, 16'd4);
    check("busy_biglen_state", state_dbg, S_IDLE);
    pulse_ack();
    check("busy_ack_clears", buffer_valid, 1'b0);
    pulse_ack();
    check("ack_when_empty", buffer_valid, 1'b0);

    // Timeout: fires on the TIMEOUT_CYCLES-th quiet edge after a byte
    send_byte(8'hD5);
    send_byte(8'h02);
    send_byte(8'hAA);
    idle_cycles(TIMEOUT_CYCLES - 1);
    check("tmo_not_yet", err_cnt, 16'd4);
    check("tmo_state_payload", state_dbg, S_PAYLOAD);
    idle_cycles(1);
    check("tmo_strobe", err_strobe, 1'b1);
    check("tmo_code", err_code, 3'd3);
    check("tmo_err_cnt", err_cnt, 16'd5);
    check("tmo_state_idle", state_dbg, S_IDLE);
    send_one_01();
    check("tmo_recover_pkt", pkt_cnt, 16'd5);
    pulse_ack();

    // Byte on the expiry cycle wins over the timeout
    send_byte(8'hD5);
    idle_cycles(TIMEOUT_CYCLES - 1);
    check("race_state_len", state_dbg, S_LEN);
    send_byte(8'h01);
    check("race_no_err", err_cnt, 16'd5);
    check("race_state_payload", state_dbg, S_PAYLOAD);
    send_byte(8'h01);
    send_byte(8'h5E);
    check("race_pkt_cnt", pkt_cnt, 16'd6);

    // Reset mid-packet
    send_byte(8'hD5);
    send_byte(8'h05);
    send_byte(8'hAA);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", buffer_valid, 1'b0);
    check("midrst_len", payload_len, 8'h00);
    check("midrst_code", err_code, 3'd0);
    check("midrst_pkt_cnt", pkt_cnt, 16'd0);
    check("midrst_err_cnt", err_cnt, 16'd0);
    check("midrst_rd_data", rd_data, 8'h00);
    check("midrst_state", state_dbg, S_IDLE);
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h5E);
    check("postrst_no_sof_pkt", pkt_cnt, 16'd0);
    check("postrst_no_err", err_cnt, 16'd0);
    send_one_01();
    check("postrst_pkt_cnt", pkt_cnt, 16'd1);
    check("postrst_valid", buffer_valid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
